// File: rtl/bank_arbiter_pkg.sv
// Shared definitions for the two-requester bank arbiter: FSM state
// encoding, default geometry and a small sizing helper.
package bank_arbiter_pkg;

   // Arbiter ownership states; G0/G1 are one-hot so each grant maps to one bit
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_G0   = 2'b01,
      ST_G1   = 2'b10
   } state_t;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_NREG     = 4;
   localparam int DEF_AW       = 2;
   localparam int DEF_MAX_HOLD = 4;

   // Bits needed for a counter that must be able to hold the value max_hold
   function automatic int hold_bits(input int max_hold);
      return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
   endfunction

endpackage

// File: rtl/bank_arbiter_reg_bank.sv
// NREG x WIDTH register bank built from individual flop cells, with a
// registered read port. Addresses at or above NREG match no cell, so writes
// there are dropped and reads there return zero.
module reg_bank
   import bank_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREG  = DEF_NREG,
   parameter int AW    = DEF_AW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_we,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_rvalid
);

   logic [WIDTH-1:0] w_cells [NREG];
   logic [WIDTH-1:0] w_rd_mux;
   logic             w_rd_en;
   logic [WIDTH-1:0] r_rdata;
   logic             r_rvalid;

   assign w_rd_en = i_en & ~i_we;

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_cell
         logic [WIDTH-1:0] r_q;
         logic             w_sel;

         assign w_sel = i_en & i_we & (i_addr == AW'(gi));

         // Storage cell: loads only when it is the write target this edge
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_q <= '0;
            end else if (w_sel) begin
               r_q <= i_wdata;
            end
         end

         assign w_cells[gi] = r_q;
      end
   endgenerate

   // Read select; an address with no matching cell leaves the mux at zero
   always_comb begin
      w_rd_mux = '0;
      for (int i = 0; i < NREG; i++) begin
         if (i_addr == AW'(i)) begin
            w_rd_mux = w_cells[i];
         end
      end
   end

   // Registered read port: rvalid pulses for exactly one cycle per read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= w_rd_en;
         if (w_rd_en) begin
            r_rdata <= w_rd_mux;
         end
      end
   end

   assign o_rdata  = r_rdata;
   assign o_rvalid = r_rvalid;

endmodule

// File: rtl/bank_arbiter.sv
// Round-robin arbiter for two requesters sharing one register bank. The
// owner's address/write-enable/data are muxed into the bank; a hold counter
// forces a hand-over after MAX_HOLD back-to-back accesses while the other
// side is waiting, so neither requester can starve the other.
module bank_arbiter
   import bank_arbiter_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NREG     = DEF_NREG,
   parameter int AW       = DEF_AW,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             we0,
   input  logic [AW-1:0]    addr0,
   input  logic [WIDTH-1:0] wdata0,
   input  logic             req1,
   input  logic             we1,
   input  logic [AW-1:0]    addr1,
   input  logic [WIDTH-1:0] wdata1,
   output logic             gnt0,
   output logic             gnt1,
   output logic [WIDTH-1:0] rdata,
   output logic             rvalid
);

   localparam int             HW       = hold_bits(MAX_HOLD);
   localparam logic [HW:0]    HOLD_LIM = (HW + 1)'(MAX_HOLD);

   state_t           r_state;
   logic             r_gnt0;
   logic             r_gnt1;
   logic [HW-1:0]    r_hold;
   logic             r_last;      // requester that most recently gave up the bank

   logic             w_acc0;
   logic             w_acc1;
   logic             w_acc;
   logic             w_we;
   logic [AW-1:0]    w_addr;
   logic [WIDTH-1:0] w_wdata;
   logic [HW:0]      w_hold_p1;
   logic [HW-1:0]    w_hold_sat;
   logic             w_limit;

   // An access happens only when the owner is still requesting
   assign w_acc0 = r_gnt0 & req0;
   assign w_acc1 = r_gnt1 & req1;
   assign w_acc  = w_acc0 | w_acc1;

   // Request mux into the bank; grants are exclusive so a 2:1 select suffices
   assign w_we    = w_acc0 ? we0    : we1;
   assign w_addr  = w_acc0 ? addr0  : addr1;
   assign w_wdata = w_acc0 ? wdata0 : wdata1;

   // Hold count including the access taking place at this edge
   assign w_hold_p1  = {1'b0, r_hold} + (HW + 1)'(1);
   assign w_limit    = (w_hold_p1 >= HOLD_LIM);
   assign w_hold_sat = w_limit ? HOLD_LIM[HW-1:0] : w_hold_p1[HW-1:0];

   // Ownership FSM with registered grants, hold counter and fairness bit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_hold  <= '0;
         r_last  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_hold <= '0;
               // On a tie, the requester that was not served last wins
               if (req0 && (!req1 || r_last)) begin
                  r_state <= ST_G0;
                  r_gnt0  <= 1'b1;
                  r_gnt1  <= 1'b0;
               end else if (req1) begin
                  r_state <= ST_G1;
                  r_gnt0  <= 1'b0;
                  r_gnt1  <= 1'b1;
               end else begin
                  r_gnt0  <= 1'b0;
                  r_gnt1  <= 1'b0;
               end
            end

            ST_G0: begin
               if (!req0 || (req1 && w_limit)) begin
                  r_last <= 1'b0;
                  r_hold <= '0;
                  r_gnt0 <= 1'b0;
                  if (req1) begin
                     r_state <= ST_G1;
                     r_gnt1  <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                     r_gnt1  <= 1'b0;
                  end
               end else begin
                  r_hold <= w_hold_sat;
               end
            end

            ST_G1: begin
               if (!req1 || (req0 && w_limit)) begin
                  r_last <= 1'b1;
                  r_hold <= '0;
                  r_gnt1 <= 1'b0;
                  if (req0) begin
                     r_state <= ST_G0;
                     r_gnt0  <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                     r_gnt0  <= 1'b0;
                  end
               end else begin
                  r_hold <= w_hold_sat;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_gnt0  <= 1'b0;
               r_gnt1  <= 1'b0;
               r_hold  <= '0;
            end
         endcase
      end
   end

   reg_bank #(
      .WIDTH (WIDTH),
      .NREG  (NREG),
      .AW    (AW)
   ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .i_en     (w_acc),
      .i_we     (w_we),
      .i_addr   (w_addr),
      .i_wdata  (w_wdata),
      .o_rdata  (rdata),
      .o_rvalid (rvalid)
   );

   assign gnt0 = r_gnt0;
   assign gnt1 = r_gnt1;

endmodule

// File: tb/tb_bank_arbiter.sv
// Bench for bank_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a tenure-based reference model.
module tb_bank_arbiter;

   localparam int WIDTH    = 8;
   localparam int NREG     = 3;
   localparam int AW       = 2;
   localparam int MAX_HOLD = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0, we0, req1, we1;
   logic [AW-1:0]    addr0, addr1;
   logic [WIDTH-1:0] wdata0, wdata1;
   logic             gnt0, gnt1, rvalid;
   logic [WIDTH-1:0] rdata;

   int tests = 0;
   int fails = 0;

   // Reference model: who owns the bank, how many accesses this tenure
   int               m_owner;     // -1 = nobody
   int               m_run;
   int               m_last;
   logic [WIDTH-1:0] m_mem [4];
   logic [WIDTH-1:0] m_rdata;
   logic             m_rvalid;

   always #5 clk = ~clk;

   bank_arbiter #(
      .WIDTH(WIDTH), .NREG(NREG), .AW(AW), .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata), .rvalid(rvalid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner  = -1;
      m_run    = 0;
      m_last   = 1;
      m_rdata  = '0;
      m_rvalid = 1'b0;
      for (int i = 0; i < 4; i++) m_mem[i] = '0;
   endtask

   // One rising edge of the model: owner's access first, then hand-over rules
   task automatic model_edge();
      bit               rq [2];
      bit               wq [2];
      int               ad [2];
      logic [WIDTH-1:0] wd [2];
      int               other;
      rq[0] = req0;  rq[1] = req1;
      wq[0] = we0;   wq[1] = we1;
      ad[0] = int'(addr0); ad[1] = int'(addr1);
      wd[0] = wdata0; wd[1] = wdata1;
      m_rvalid = 1'b0;
      if (m_owner >= 0) begin
         if (rq[m_owner]) begin
            m_run++;
            if (wq[m_owner]) begin
               if (ad[m_owner] < NREG) m_mem[ad[m_owner]] = wd[m_owner];
            end else begin
               m_rdata  = (ad[m_owner] < NREG) ? m_mem[ad[m_owner]] : '0;
               m_rvalid = 1'b1;
            end
         end
         other = 1 - m_owner;
         if (!rq[m_owner]) begin
            m_last  = m_owner;
            m_owner = rq[other] ? other : -1;
            m_run   = 0;
         end else if (rq[other] && m_run >= MAX_HOLD) begin
            m_last  = m_owner;
            m_owner = other;
            m_run   = 0;
         end
      end else begin
         if (rq[0] && rq[1]) m_owner = 1 - m_last;
         else if (rq[0])     m_owner = 0;
         else if (rq[1])     m_owner = 1;
         m_run = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("gnt0", 32'(gnt0), 32'(m_owner == 0));
      check("gnt1", 32'(gnt1), 32'(m_owner == 1));
      check("exclusive", 32'(gnt0 & gnt1), 32'd0);
      check("rvalid", 32'(rvalid), 32'(m_rvalid));
      check("rdata", 32'(rdata), 32'(m_rdata));
   endtask

   task automatic idle_inputs();
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
   endtask

   initial begin
      // Power-on reset held for two cycles
      reset = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt0", 32'(gnt0), 32'd0);
      check("rst_gnt1", 32'(gnt1), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      reset = 1'b1;

      // First grant and write of A5 to register 2
      req0 = 1; we0 = 1; addr0 = 2'd2; wdata0 = 8'hA5;
      tick();
      check("first_gnt0", 32'(gnt0), 32'd1);
      check("first_gnt1", 32'(gnt1), 32'd0);
      tick();
      check("write_gnt1_low", 32'(gnt1), 32'd0);

      // Read-back latency: data one cycle after the access edge, then rvalid drops
      we0 = 0;
      tick();
      check("read_a5_data", 32'(rdata), 32'hA5);
      check("read_a5_valid", 32'(rvalid), 32'd1);
      req0 = 0;
      tick();
      check("rvalid_pulse_end", 32'(rvalid), 32'd0);
      check("drop_gnt0", 32'(gnt0), 32'd0);

      // Simultaneous requests right after reset: requester 0 first, then direct switch
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 2'd0; addr1 = 2'd1;
      tick();
      check("tie_gnt0", 32'(gnt0), 32'd1);
      check("tie_gnt1", 32'(gnt1), 32'd0);
      tick();
      req0 = 0;
      tick();
      check("switch_gnt1", 32'(gnt1), 32'd1);
      check("switch_gnt0", 32'(gnt0), 32'd0);
      req1 = 0;
      tick();

      // Hold limit: both requesting continuously, ownership alternates every MAX_HOLD accesses
      req0 = 1; req1 = 1; we0 = 1; we1 = 1;
      tick();
      for (int k = 0; k < 16; k++) begin
         addr0 = AW'(k % 3);       wdata0 = WIDTH'(k);
         addr1 = AW'((k + 1) % 3); wdata1 = WIDTH'(k + 'h40);
         check("hold_owner0", 32'(gnt0), 32'(((k / MAX_HOLD) % 2) == 0));
         check("hold_owner1", 32'(gnt1), 32'(((k / MAX_HOLD) % 2) == 1));
         tick();
      end
      idle_inputs();
      tick();

      // Out-of-range address: write ignored, read yields zero with rvalid
      req0 = 1; we0 = 1; addr0 = 2'd3; wdata0 = 8'hFF;
      tick();
      tick();
      we0 = 0;
      tick();
      check("oor_rdata", 32'(rdata), 32'd0);
      check("oor_rvalid", 32'(rvalid), 32'd1);
      for (int a = 0; a < NREG; a++) begin
         addr0 = AW'(a);
         tick();
      end
      idle_inputs();
      tick();

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         req0   = ($urandom_range(3) != 0);
         req1   = ($urandom_range(3) != 0);
         we0    = $urandom_range(1);
         we1    = $urandom_range(1);
         addr0  = AW'($urandom_range(3));
         addr1  = AW'($urandom_range(3));
         wdata0 = WIDTH'($urandom);
         wdata1 = WIDTH'($urandom);
         tick();
      end

      // Mid-operation reset while requester 1 owns the bank with a write pending
      idle_inputs();
      req1 = 1;
      tick();
      tick();
      check("pre_rst_gnt1", 32'(gnt1), 32'd1);
      we1 = 1; addr1 = 2'd1; wdata1 = 8'h3C;
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_gnt1", 32'(gnt1), 32'd0);
      check("async_rst_gnt0", 32'(gnt0), 32'd0);
      check("async_rst_rvalid", 32'(rvalid), 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;

      // Tie after reset goes to requester 0; then read back every register
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 2'd0; addr1 = 2'd0;
      tick();
      check("post_rst_tie_gnt0", 32'(gnt0), 32'd1);
      for (int a = 0; a < NREG; a++) begin
         addr0 = AW'(a);
         tick();
         check("post_rst_zero", 32'(rdata), 32'd0);
         check("post_rst_valid", 32'(rvalid), 32'd1);
      end
      idle_inputs();
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
